// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard.
//   NREGS    : architectural register count (register 0 is hard-wired zero)
//   REG_AW   : register index width
//   MAX_LAT  : largest producer latency the scoreboard tracks
//   LAT_W    : width of a per-register countdown
//   ZERO_REG : index of the hard-wired zero register
//   lat_t    : latency / countdown type
//   clamp_lat: limits a requested latency to MAX_LAT
package hazard_pkg;

  localparam int NREGS   = 32;
  localparam int REG_AW  = 5;
  localparam int MAX_LAT = 4;
  localparam int LAT_W   = 3;

  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  typedef logic [LAT_W-1:0] lat_t;

  function automatic lat_t clamp_lat(input lat_t lat);
    return (lat > lat_t'(MAX_LAT)) ? lat_t'(MAX_LAT) : lat;
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One register's countdown in the hazard scoreboard.
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset, overrides freeze
//   set     : a producer targeting this register issues this cycle
//   set_val : producer latency L (already clamped to MAX_LAT)
//   freeze  : whole pipeline held; the count does not move
//   busy    : count is nonzero, a reader of this register must stall
module hazard_sb_entry
  import hazard_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  lat_t set_val,
  input  logic freeze,
  output logic busy
);

  lat_t cnt;
  lat_t cnt_dec;
  lat_t set_rem;

  // The count holds the number of cycles a reader in ID still has to stall.
  // The issue cycle itself is the first of the producer's L cycles, so a new
  // producer leaves L-1 stall cycles behind it (L of 0 or 1 means none).
  assign cnt_dec = (cnt != '0) ? cnt - lat_t'(1) : '0;
  assign set_rem = (set_val != '0) ? set_val - lat_t'(1) : '0;

  // NOTE: state is updated with non-blocking assignments only, so every
  // entry samples the same pre-edge values no matter the evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!freeze) begin
      // On WAW the older, longer-running result keeps the register busy.
      if (set && (set_rem > cnt_dec)) cnt <= set_rem;
      else                            cnt <= cnt_dec;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit built on a per-register countdown scoreboard.
// A producer issuing from ID marks its destination busy for the cycles its
// result is not yet usable; readers of a busy register stall ID.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   id_valid           : valid instruction in ID
//   id_single_src      : only src1 is read
//   id_src1, id_src2   : source registers
//   id_wb_en, id_dest  : destination write enable and index
//   id_lat_fwd         : latency until the result can be forwarded
//   id_lat_wb          : latency until the result reaches the register file
//   forwarding_enable  : selects id_lat_fwd (1) or id_lat_wb (0) for this issue
//   id_flush           : ID instruction killed this cycle
//   pipe_freeze        : whole pipeline held
//   hazard_detected    : stall ID (combinational)
//   busy_mask          : per-register busy flags, bit 0 always 0
//   stall_cycles       : saturating count of non-frozen stall cycles,
//                        present only when HAZARD_SB_STATS_EN is defined
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_single_src,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_wb_en,
  input  logic [REG_AW-1:0] id_dest,
  input  lat_t              id_lat_fwd,
  input  lat_t              id_lat_wb,
  input  logic              forwarding_enable,
  input  logic              id_flush,
  input  logic              pipe_freeze,
  output logic              hazard_detected,
  output logic [NREGS-1:0]  busy_mask
`ifdef HAZARD_SB_STATS_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  logic src1_busy;
  logic src2_busy;
  logic issue;
  lat_t issue_lat;

  // Register 0 has no entry, so its busy bit is a constant 0 and reads of
  // it can never raise a hazard.
  assign busy_mask[0] = 1'b0;

  assign src1_busy = busy_mask[id_src1];
  assign src2_busy = busy_mask[id_src2] & ~id_single_src;

  assign hazard_detected = id_valid & ~id_flush & (src1_busy | src2_busy);

  // The scoreboard is read before it is written, so an instruction whose
  // destination equals its own source never hazards against itself.
  assign issue = id_valid & ~hazard_detected & ~id_flush & ~pipe_freeze &
                 id_wb_en & (id_dest != ZERO_REG);

  assign issue_lat = clamp_lat(forwarding_enable ? id_lat_fwd : id_lat_wb);

  for (genvar r = 1; r < NREGS; r++) begin : g_entry
    hazard_sb_entry u_entry (
      .clk     (clk),
      .rst     (rst),
      .set     (issue && (id_dest == REG_AW'(r))),
      .set_val (issue_lat),
      .freeze  (pipe_freeze),
      .busy    (busy_mask[r])
    );
  end

`ifdef HAZARD_SB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (hazard_detected && !pipe_freeze && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
